// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Next-PC controller and instruction-fetch sequencer for the RISC-V front end.
//   Owns the architectural fetch PC, runs a req/ack handshake to instruction
//   memory and presents one registered instruction at a time to IF/ID.
//
// Ports
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   stall_i          hazard stall; the held IF/ID instruction must not advance
//   redirect_i       taken branch/jump from EX, target on redirect_pc_i
//   trap_i           trap request; wins over redirect, target is TRAP_VEC
//   imem_req_o       instruction memory request
//   imem_addr_o      fetch address, stable while a request waits for ack
//   imem_ack_i       request accepted, imem_rdata_i valid this cycle
//   imem_rdata_i     fetched instruction word
//   if_valid_o       if_pc_o / if_instr_o hold a valid instruction
//   if_pc_o          PC of if_instr_o
//   if_instr_o       instruction handed to decode
//   flush_o          combinational pulse in the trap/redirect cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fetch_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        trap_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        flush_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_SQUASH = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] sq_addr_q, sq_addr_d;   // address of the request being squashed
  logic        valid_q, valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] instr_q, instr_d;

  logic        event_hit;
  logic [31:0] event_pc;
  logic        slot_busy;
  logic        fetch_active;

  assign event_hit    = trap_i | redirect_i;
  assign event_pc     = trap_i ? TRAP_VEC : {redirect_pc_i[31:2], 2'b00};
  // The IF/ID slot is occupied and will not be consumed this cycle, so
  // there is nowhere to put a new word: no request is issued.
  assign slot_busy    = valid_q & stall_i;
  assign fetch_active = (state_q == S_FETCH) || (state_q == S_HOLD);

  assign imem_req_o  = (state_q == S_SQUASH) | (fetch_active & ~slot_busy);
  // While squashing, the old request must complete at its original address
  // even though pc_q already holds the new target.
  assign imem_addr_o = (state_q == S_SQUASH) ? sq_addr_q : pc_q;
  assign flush_o     = event_hit & (state_q != S_IDLE);

  assign if_valid_o  = valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_instr_o  = instr_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    sq_addr_d = sq_addr_q;
    valid_d   = valid_q;
    if_pc_d   = if_pc_q;
    instr_d   = instr_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_SQUASH: begin
        // Further events only retarget; the outstanding request still drains.
        if (event_hit) pc_d = event_pc;
        if (imem_ack_i) state_d = S_FETCH;
      end

      default: begin  // S_FETCH and S_HOLD share the slot/handshake rules
        if (event_hit) begin
          pc_d    = event_pc;
          valid_d = 1'b0;
          if (imem_req_o && !imem_ack_i) begin
            state_d   = S_SQUASH;
            sq_addr_d = pc_q;
          end else begin
            state_d = S_FETCH;
          end
        end else if (slot_busy) begin
          state_d = S_HOLD;
        end else if (imem_ack_i) begin
          valid_d = 1'b1;
          if_pc_d = pc_q;
          instr_d = imem_rdata_i;
          pc_d    = pc_q + 32'd4;   // modulo 2^32 wrap is intended
          state_d = stall_i ? S_HOLD : S_FETCH;
        end else begin
          // Either the held word is consumed now or the slot was already empty.
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_VEC;
      sq_addr_q <= 32'h0;
      valid_q   <= 1'b0;
      if_pc_q   <= 32'h0;
      instr_q   <= NOP;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sq_addr_q <= sq_addr_d;
      valid_q   <= valid_d;
      if_pc_q   <= if_pc_d;
      instr_q   <= instr_d;
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Next-PC controller and instruction-fetch sequencer for the RISC-V pipeline front end.
- Owns the architectural fetch PC and selects its next value: trap vector, EX redirect, hold, or PC+4.
- Drives a request/acknowledge handshake to instruction memory and delivers one registered instruction per fetch to the IF/ID boundary.
- Squashes in-flight fetches on redirect and holds under hazard stall.

Parameters:
- RESET_VEC, 32'h0000_0000, PC loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded when a trap is taken.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hazard stall from hazard detection; IF/ID must hold.
- redirect_i  input  1  taken branch/jump resolved in EX.
- redirect_pc_i  input  32  redirect target (ALU output).
- trap_i  input  1  trap/exception request.
- imem_req_o  output  1  instruction memory request.
- imem_addr_o  output  32  fetch address; stable while imem_req_o=1 and no ack.
- imem_ack_i  input  1  memory accepted the request, imem_rdata_i valid this cycle.
- imem_rdata_i  input  32  fetched instruction word.
- if_valid_o  output  1  if_instr_o/if_pc_o hold a valid instruction.
- if_pc_o  output  32  PC of if_instr_o.
- if_instr_o  output  32  instruction to decode.
- flush_o  output  1  one-cycle pulse: invalidate younger pipeline stages.

Behaviour:
- Reset (async assert): state=IDLE, pc=RESET_VEC, imem_req_o=0, imem_addr_o=RESET_VEC, if_valid_o=0, if_pc_o=0, if_instr_o=32'h0000_0013 (NOP), flush_o=0.
- States: IDLE, FETCH, SQUASH, HOLD.
- IDLE:
  - Entered only from reset.
  - First clock after rst_n deasserts goes to FETCH.
  - imem_req_o=0.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc.
  - Ack in the same cycle as the request is legal.
  - On imem_ack_i with no event: if_valid_o<=1, if_pc_o<=pc, if_instr_o<=imem_rdata_i, pc<=pc+4.
  - After such an ack: stay in FETCH if stall_i=0; go to HOLD if stall_i=1.
  - Steady-state throughput with a zero-wait memory: one instruction per cycle.
- HOLD:
  - if_* outputs frozen and imem_req_o=0 while stall_i=1.
  - Return to FETCH when stall_i=0. The instruction is consumed that cycle; the next request issues in the same cycle.
- Consumption rule: the consumer takes if_instr_o when if_valid_o=1 and stall_i=0.
  - If FETCH has no ack that cycle, if_valid_o<=0 after consumption.
- Event priority: trap_i > redirect_i > stall_i > sequential.
- Trap or redirect in any non-IDLE state:
  - pc<=TRAP_VEC, or pc<={redirect_pc_i[31:2],2'b00}. Bits [1:0] are forced to zero.
  - if_valid_o<=0 and flush_o=1 for exactly that cycle (registered pulse next cycle is not allowed; flush_o is combinational from trap_i|redirect_i gated by state!=IDLE).
  - If a request is outstanding (FETCH, imem_req_o=1, no ack this cycle): go to SQUASH.
  - If the ack arrives in the event cycle: drop imem_rdata_i and go to FETCH with the new pc.
  - From HOLD: go to FETCH.
- SQUASH:
  - imem_req_o=1, imem_addr_o=old address (the request must complete).
  - On ack: discard data and go to FETCH at the new pc; if_valid_o stays 0.
  - A further redirect/trap in SQUASH updates the target pc only; it takes effect when SQUASH exits.
- Stall and redirect in the same cycle: redirect wins; stall is ignored for the squashed slot.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- imem_addr_o never changes while imem_req_o=1 and imem_ack_i=0.
- Reset mid-transaction: everything returns to reset values immediately; a late ack after reset is ignored because state is IDLE.

Test Plan:
- Reset release, zero-wait memory always acking:
  - Required: imem_addr_o sequence 0x0, 0x4, 0x8.
  - Required: if_valid_o=1 from the cycle after the first ack.
  - Required: if_pc_o trails imem_addr_o by one cycle.
- Memory with 2-cycle ack latency:
  - Required: imem_addr_o stays at 0x4 for 3 cycles.
  - Required: one if_valid_o per ack; no duplicate if_pc_o values.
- stall_i=1 for 3 cycles while if_pc_o=0x8:
  - Required: if_pc_o/if_instr_o frozen and imem_req_o=0.
  - Required: after stall_i=0, next fetch address is 0xC.
- redirect_i=1, redirect_pc_i=0x103 while a fetch of 0x10 is outstanding:
  - Required: flush_o pulses for 1 cycle and the state enters SQUASH.
  - Required: the 0x10 data is discarded and the next request address is 0x100.
- trap_i and redirect_i asserted together (redirect_pc_i=0x40):
  - Required: pc becomes TRAP_VEC (0x100) and flush_o=1.
- PC at 0xFFFF_FFFC fetched, then async reset asserted while the next request is outstanding:
  - Required: next address is 0x0 (wrap).
  - Required: reset clears if_valid_o immediately; a late ack is ignored.
  - Required: fetch restarts at RESET_VEC.
